// File: rtl/fmul_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fmul_pkg -- shared exponent constants and per-lane flag record | rev 1.0
// ---------------------------------------------------------------------------
package fmul_pkg;

  function automatic int bias(input int expwidth);
    return (1 << (expwidth - 1)) - 1;
  endfunction

  function automatic int pad(input int precision);
    return precision + 2;
  endfunction

  function automatic int maxnormexp(input int expwidth);
    return (1 << expwidth) - 2;
  endfunction

  typedef struct packed {
    logic special_valid;
    logic nan;
    logic inf;
    logic inv;
    logic haszero;
    logic early_ov;
    logic prod_sign;
    logic may_be_sub;
  } lane_flags_t;

endpackage
`default_nettype wire

// File: rtl/fmul_s1_vec_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fmul_s1_vec_if -- operand/result handshake bundle of the vector FMUL s1 | rev 1.0
// ---------------------------------------------------------------------------
interface fmul_s1_vec_if #(
  parameter int EXPWIDTH  = 8,
  parameter int PRECISION = 24,
  parameter int NUM_LANES = 4,
  parameter int TAG_WIDTH = 8
);
  localparam int OPW = NUM_LANES * (EXPWIDTH + PRECISION);
  localparam int VW  = NUM_LANES * (EXPWIDTH + 1);

  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [OPW-1:0]       a_i;
  logic [OPW-1:0]       b_i;
  logic [2:0]           rm_i;
  logic                 ftz_i;
  logic [NUM_LANES-1:0] lane_mask_i;
  logic [TAG_WIDTH-1:0] tag_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [NUM_LANES-1:0] out_special_valid_o, out_nan_o, out_inf_o, out_inv_o;
  logic [NUM_LANES-1:0] out_haszero_o, out_early_ov_o, out_prod_sign_o, out_may_be_sub_o;
  logic [VW-1:0]        out_shift_amt_o;
  logic [VW-1:0]        out_exp_shifted_o;
  logic [2:0]           out_rm_o;
  logic [NUM_LANES-1:0] out_lane_mask_o;
  logic [TAG_WIDTH-1:0] out_tag_o;
  logic                 flag_clr_i;
  logic                 flag_inv_o;
  logic                 flag_ftz_o;

  modport slave (
    input  in_valid_i, a_i, b_i, rm_i, ftz_i, lane_mask_i, tag_i, out_ready_i, flag_clr_i,
    output in_ready_o, out_valid_o, out_special_valid_o, out_nan_o, out_inf_o, out_inv_o,
           out_haszero_o, out_early_ov_o, out_prod_sign_o, out_may_be_sub_o,
           out_shift_amt_o, out_exp_shifted_o, out_rm_o, out_lane_mask_o, out_tag_o,
           flag_inv_o, flag_ftz_o
  );

  modport master (
    output in_valid_i, a_i, b_i, rm_i, ftz_i, lane_mask_i, tag_i, out_ready_i, flag_clr_i,
    input  in_ready_o, out_valid_o, out_special_valid_o, out_nan_o, out_inf_o, out_inv_o,
           out_haszero_o, out_early_ov_o, out_prod_sign_o, out_may_be_sub_o,
           out_shift_amt_o, out_exp_shifted_o, out_rm_o, out_lane_mask_o, out_tag_o,
           flag_inv_o, flag_ftz_o
  );
endinterface
`default_nettype wire

// File: rtl/fmul_s1_lane.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fmul_s1_lane -- combinational stage-1 datapath for one multiplier lane | rev 1.0
// ---------------------------------------------------------------------------
module fmul_s1_lane
  import fmul_pkg::*;
#(
  parameter int EXPWIDTH  = 8,
  parameter int PRECISION = 24
) (
  input  logic [EXPWIDTH+PRECISION-1:0] a_i,
  input  logic [EXPWIDTH+PRECISION-1:0] b_i,
  input  logic                          ftz_i,
  output lane_flags_t                   flags_o,
  output logic                          flushed_o,
  output logic [EXPWIDTH:0]             shift_amt_o,
  output logic [EXPWIDTH:0]             exp_shifted_o
);
  localparam int W          = EXPWIDTH + PRECISION;
  localparam int FW         = PRECISION - 1;
  localparam int LZW        = 2 * PRECISION + 2;
  localparam int CW         = $clog2(LZW + 1);
  localparam int BIAS       = bias(EXPWIDTH);
  localparam int PAD        = pad(PRECISION);
  localparam int MAXNORMEXP = maxnormexp(EXPWIDTH);
  localparam logic [EXPWIDTH:0]   PROD_OFF = (EXPWIDTH + 1)'(BIAS - PAD - 1);
  localparam logic [EXPWIDTH+1:0] LIM_OFF  = (EXPWIDTH + 2)'(BIAS - PAD);
  localparam logic [EXPWIDTH:0]   OV_LIM   = (EXPWIDTH + 1)'(MAXNORMEXP + BIAS);

  logic [W-1:0]         op      [2];
  logic [EXPWIDTH-1:0]  raw_exp [2];
  logic [PRECISION-1:0] raw_sig [2];
  logic [1:0] sign, exp_zero, is_zero, is_inf, is_nan, is_snan, flushed;

  assign op[0] = a_i;
  assign op[1] = b_i;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sign[i]     = op[i][W-1];
      exp_zero[i] = (op[i][W-2 -: EXPWIDTH] == '0);
      flushed[i]  = ftz_i & exp_zero[i] & (op[i][FW-1:0] != '0);
      is_zero[i]  = exp_zero[i] & ((op[i][FW-1:0] == '0) | ftz_i);
      is_inf[i]   = (&op[i][W-2 -: EXPWIDTH]) & (op[i][FW-1:0] == '0);
      is_nan[i]   = (&op[i][W-2 -: EXPWIDTH]) & (op[i][FW-1:0] != '0);
      is_snan[i]  = is_nan[i] & ~op[i][FW-1];
      raw_exp[i]  = op[i][W-2 -: EXPWIDTH] | EXPWIDTH'(exp_zero[i]);
      raw_sig[i]  = flushed[i] ? '0 : {~exp_zero[i], op[i][FW-1:0]};
    end
  end

  logic [EXPWIDTH:0]   exp_sum, prod_exp, shift_lim, lzc_ext, shift_amt;
  logic [EXPWIDTH+1:0] shift_lim_sub;
  logic [LZW-1:0]      lzc_in;
  logic [CW-1:0]       lzc_cnt;
  logic                uf, exceed, has_zero, has_inf, has_nan, zero_inf;

  assign exp_sum       = {1'b0, raw_exp[0]} + {1'b0, raw_exp[1]};
  assign prod_exp      = exp_sum - PROD_OFF;
  assign shift_lim_sub = {1'b0, exp_sum} - LIM_OFF;
  assign uf            = shift_lim_sub[EXPWIDTH+1];
  assign shift_lim     = shift_lim_sub[EXPWIDTH:0];

  // Only a subnormal operand can carry leading zeros; a's takes priority.
  assign lzc_in = {{(PRECISION + 2){1'b0}}, (exp_zero[0] ? raw_sig[0] : raw_sig[1])};

  lzc #(.WIDTH(LZW), .MODE(1)) u_lzc (.in_i(lzc_in), .cnt_o(lzc_cnt));

  assign lzc_ext       = (EXPWIDTH + 1)'(lzc_cnt);
  assign exceed        = (shift_lim <= lzc_ext);
  assign shift_amt     = uf ? '0 : (exceed ? shift_lim : lzc_ext);
  assign shift_amt_o   = shift_amt;
  assign exp_shifted_o = prod_exp - shift_amt;
  assign flushed_o     = |flushed;

  assign has_zero = |is_zero;
  assign has_inf  = |is_inf;
  assign has_nan  = |is_nan;
  assign zero_inf = has_zero & has_inf;

  always_comb begin
    flags_o               = '0;
    flags_o.special_valid = has_zero | has_nan | has_inf;
    flags_o.nan           = has_nan | zero_inf;
    flags_o.inf           = has_inf;
    flags_o.inv           = (|is_snan) | zero_inf;
    flags_o.haszero       = has_zero;
    flags_o.early_ov      = (exp_sum > OV_LIM);
    flags_o.prod_sign     = sign[0] ^ sign[1];
    flags_o.may_be_sub    = exceed | uf;
  end
endmodule
`default_nettype wire

// File: rtl/lzc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lzc -- leading (MODE=1) or trailing (MODE=0) zero count; all-zero gives WIDTH | rev 1.0
// ---------------------------------------------------------------------------
module lzc #(
  parameter int WIDTH     = 8,
  parameter int MODE      = 1,
  parameter int CNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);
  // Last hit in scan order wins: highest set bit for MODE=1, lowest for MODE=0.
  always_comb begin
    cnt_o = CNT_WIDTH'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (MODE != 0) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
      end else begin
        if (in_i[WIDTH-1-i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/fmul_s1_vec.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fmul_s1_vec -- multi-lane FMUL stage 1: handshake, masked output register, sticky flags | rev 1.0
// ---------------------------------------------------------------------------
module fmul_s1_vec
  import fmul_pkg::*;
#(
  parameter int EXPWIDTH  = 8,
  parameter int PRECISION = 24,
  parameter int NUM_LANES = 4,
  parameter int TAG_WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  fmul_s1_vec_if.slave   bus
);
  localparam int OW = EXPWIDTH + PRECISION;
  localparam int VW = EXPWIDTH + 1;

  lane_flags_t          lane_flags   [NUM_LANES];
  logic [VW-1:0]        lane_shift   [NUM_LANES];
  logic [VW-1:0]        lane_exp     [NUM_LANES];
  logic [NUM_LANES-1:0] lane_flushed;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    fmul_s1_lane #(.EXPWIDTH(EXPWIDTH), .PRECISION(PRECISION)) u_lane (
      .a_i          (bus.a_i[l*OW +: OW]),
      .b_i          (bus.b_i[l*OW +: OW]),
      .ftz_i        (bus.ftz_i),
      .flags_o      (lane_flags[l]),
      .flushed_o    (lane_flushed[l]),
      .shift_amt_o  (lane_shift[l]),
      .exp_shifted_o(lane_exp[l])
    );
  end

  lane_flags_t                  flags_q [NUM_LANES], flags_d [NUM_LANES];
  logic [NUM_LANES*VW-1:0]      shift_q, shift_d, exps_q, exps_d;
  logic [2:0]                   rm_q, rm_d;
  logic [NUM_LANES-1:0]         mask_q, mask_d;
  logic [TAG_WIDTH-1:0]         tag_q, tag_d;
  logic                         valid_q, valid_d, flag_inv_q, flag_inv_d, flag_ftz_q, flag_ftz_d;
  logic                         in_ready, accept, inv_new, ftz_new;

  assign in_ready = ~valid_q | bus.out_ready_i;
  assign accept   = bus.in_valid_i & in_ready;

  always_comb begin
    valid_d = accept | (valid_q & ~bus.out_ready_i);
    flags_d = flags_q;
    shift_d = shift_q;
    exps_d  = exps_q;
    rm_d    = rm_q;
    mask_d  = mask_q;
    tag_d   = tag_q;
    inv_new = 1'b0;
    ftz_new = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      inv_new = inv_new | (bus.lane_mask_i[l] & lane_flags[l].inv);
      ftz_new = ftz_new | (bus.lane_mask_i[l] & lane_flushed[l]);
    end
    if (accept) begin
      rm_d   = bus.rm_i;
      mask_d = bus.lane_mask_i;
      tag_d  = bus.tag_i;
      for (int l = 0; l < NUM_LANES; l++) begin
        flags_d[l]           = bus.lane_mask_i[l] ? lane_flags[l] : '0;
        shift_d[l*VW +: VW]  = bus.lane_mask_i[l] ? lane_shift[l] : '0;
        exps_d[l*VW +: VW]   = bus.lane_mask_i[l] ? lane_exp[l]   : '0;
      end
    end
    // A clear drops stale state but keeps what this same transfer contributes.
    flag_inv_d = (flag_inv_q & ~bus.flag_clr_i) | (accept & inv_new);
    flag_ftz_d = (flag_ftz_q & ~bus.flag_clr_i) | (accept & ftz_new);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      shift_q    <= '0;
      exps_q     <= '0;
      rm_q       <= '0;
      mask_q     <= '0;
      tag_q      <= '0;
      flag_inv_q <= 1'b0;
      flag_ftz_q <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) flags_q[l] <= '0;
    end else begin
      valid_q    <= valid_d;
      flags_q    <= flags_d;
      shift_q    <= shift_d;
      exps_q     <= exps_d;
      rm_q       <= rm_d;
      mask_q     <= mask_d;
      tag_q      <= tag_d;
      flag_inv_q <= flag_inv_d;
      flag_ftz_q <= flag_ftz_d;
    end
  end

  logic [NUM_LANES-1:0] sv_vec, nan_vec, inf_vec, inv_vec, hz_vec, ov_vec, ps_vec, mbs_vec;

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      sv_vec[l]  = flags_q[l].special_valid;
      nan_vec[l] = flags_q[l].nan;
      inf_vec[l] = flags_q[l].inf;
      inv_vec[l] = flags_q[l].inv;
      hz_vec[l]  = flags_q[l].haszero;
      ov_vec[l]  = flags_q[l].early_ov;
      ps_vec[l]  = flags_q[l].prod_sign;
      mbs_vec[l] = flags_q[l].may_be_sub;
    end
  end

  assign bus.in_ready_o          = in_ready;
  assign bus.out_valid_o         = valid_q;
  assign bus.out_special_valid_o = sv_vec;
  assign bus.out_nan_o           = nan_vec;
  assign bus.out_inf_o           = inf_vec;
  assign bus.out_inv_o           = inv_vec;
  assign bus.out_haszero_o       = hz_vec;
  assign bus.out_early_ov_o      = ov_vec;
  assign bus.out_prod_sign_o     = ps_vec;
  assign bus.out_may_be_sub_o    = mbs_vec;
  assign bus.out_shift_amt_o     = shift_q;
  assign bus.out_exp_shifted_o   = exps_q;
  assign bus.out_rm_o            = rm_q;
  assign bus.out_lane_mask_o     = mask_q;
  assign bus.out_tag_o           = tag_q;
  assign bus.flag_inv_o          = flag_inv_q;
  assign bus.flag_ftz_o          = flag_ftz_q;
endmodule
`default_nettype wire

// File: tb/tb_fmul_s1_vec.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fmul_s1_vec -- directed and randomized checks of fmul_s1_vec (fp32, 4 lanes) | rev 1.0
// ---------------------------------------------------------------------------
module tb_fmul_s1_vec;
  localparam int E = 8, P = 24, L = 4, T = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fmul_s1_vec_if #(.EXPWIDTH(E), .PRECISION(P), .NUM_LANES(L), .TAG_WIDTH(T)) bus ();
  fmul_s1_vec #(.EXPWIDTH(E), .PRECISION(P), .NUM_LANES(L), .TAG_WIDTH(T)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  logic          e_valid, e_inv, e_ftz;
  logic [25:0]   e_rec [L];
  logic [2:0]    e_rm;
  logic [L-1:0]  e_mask;
  logic [T-1:0]  e_tag;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // fp32 reference: record = {special,nan,inf,inv,haszero,early_ov,sign,may_be_sub, shift[9], exp[9]}
  function automatic logic [25:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic ftz, output logic flushed);
    int ea, eb, fa, fb, rea, reb, siga, sigb, sig, sum, lim, lz, n, sa, pe, es;
    bit fla, flb, za, zb, ia, ib, na, nb, sna, snb, uf, exceed, hz, hi, hn, zi, ov;
    ea = int'(a[30:23]); fa = int'(a[22:0]);
    eb = int'(b[30:23]); fb = int'(b[22:0]);
    fla = ftz && ea == 0 && fa != 0;
    flb = ftz && eb == 0 && fb != 0;
    za = (ea == 0) && (fa == 0 || fla);
    zb = (eb == 0) && (fb == 0 || flb);
    ia = ea == 255 && fa == 0;  ib = eb == 255 && fb == 0;
    na = ea == 255 && fa != 0;  nb = eb == 255 && fb != 0;
    sna = na && fa < (1 << 22); snb = nb && fb < (1 << 22);
    rea = (ea == 0) ? 1 : ea;
    reb = (eb == 0) ? 1 : eb;
    siga = fla ? 0 : ((ea != 0) ? (fa + (1 << 23)) : fa);
    sigb = flb ? 0 : ((eb != 0) ? (fb + (1 << 23)) : fb);
    sum = rea + reb;
    sig = (ea == 0) ? siga : sigb;
    n = 0;
    while ((sig >> n) != 0) n++;
    lz = 50 - n;
    lim = sum - (127 - 26);
    uf = lim < 0;
    exceed = (lim & 511) <= lz;
    sa = uf ? 0 : (exceed ? lim : lz);
    pe = (sum - (127 - 26 - 1)) & 511;
    es = (pe - sa) & 511;
    hz = za | zb; hi = ia | ib; hn = na | nb; zi = hz & hi;
    ov = sum > (254 + 127);
    flushed = fla | flb;
    return {hz | hn | hi, hn | zi, hi, sna | snb | zi, hz, ov, a[31] ^ b[31], exceed | uf,
            9'(sa), 9'(es)};
  endfunction

  function automatic logic [25:0] obs_rec(input int l);
    return {bus.out_special_valid_o[l], bus.out_nan_o[l], bus.out_inf_o[l], bus.out_inv_o[l],
            bus.out_haszero_o[l], bus.out_early_ov_o[l], bus.out_prod_sign_o[l],
            bus.out_may_be_sub_o[l], bus.out_shift_amt_o[l*9 +: 9], bus.out_exp_shifted_o[l*9 +: 9]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [7:0]  e;
    logic [22:0] f;
    case ($urandom_range(0, 5))
      0: e = 8'h00;
      1: e = 8'hFF;
      2: e = 8'h01;
      3: e = 8'hFE;
      default: e = 8'($urandom);
    endcase
    f = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  function automatic logic [127:0] rnd_vec();
    logic [127:0] v;
    for (int l = 0; l < L; l++) v[l*32 +: 32] = rnd_op();
    return v;
  endfunction

  task automatic drive(input logic [127:0] a, input logic [127:0] b, input logic ftz,
                       input logic [3:0] mask, input logic [7:0] tag, input logic clr);
    bus.in_valid_i  = 1'b1;
    bus.a_i         = a;
    bus.b_i         = b;
    bus.ftz_i       = ftz;
    bus.lane_mask_i = mask;
    bus.tag_i       = tag;
    bus.rm_i        = tag[2:0];
    bus.flag_clr_i  = clr;
  endtask

  // One clock: predict the transfer from the applied inputs, then check every output.
  task automatic cycle(input string name);
    logic rdy, acc, inv_new, ftz_new, fl;
    logic [25:0] r;
    #1;
    rdy = !e_valid || bus.out_ready_i;
    chk($sformatf("%s/in_ready", name), 32'(bus.in_ready_o), 32'(rdy));
    acc = bus.in_valid_i && rdy;
    inv_new = 1'b0;
    ftz_new = 1'b0;
    if (acc) begin
      for (int l = 0; l < L; l++) begin
        r = model(bus.a_i[l*32 +: 32], bus.b_i[l*32 +: 32], bus.ftz_i, fl);
        if (bus.lane_mask_i[l]) begin
          e_rec[l] = r;
          inv_new  = inv_new | r[22];
          ftz_new  = ftz_new | fl;
        end else begin
          e_rec[l] = '0;
        end
      end
      e_rm   = bus.rm_i;
      e_mask = bus.lane_mask_i;
      e_tag  = bus.tag_i;
    end
    e_inv   = (e_inv && !bus.flag_clr_i) || inv_new;
    e_ftz   = (e_ftz && !bus.flag_clr_i) || ftz_new;
    e_valid = acc || (e_valid && !bus.out_ready_i);
    @(posedge clk);
    #1;
    chk($sformatf("%s/valid", name), 32'(bus.out_valid_o), 32'(e_valid));
    chk($sformatf("%s/tag", name), 32'(bus.out_tag_o), 32'(e_tag));
    chk($sformatf("%s/rm", name), 32'(bus.out_rm_o), 32'(e_rm));
    chk($sformatf("%s/mask", name), 32'(bus.out_lane_mask_o), 32'(e_mask));
    chk($sformatf("%s/flag_inv", name), 32'(bus.flag_inv_o), 32'(e_inv));
    chk($sformatf("%s/flag_ftz", name), 32'(bus.flag_ftz_o), 32'(e_ftz));
    for (int l = 0; l < L; l++)
      chk($sformatf("%s/lane%0d", name, l), 32'(obs_rec(l)), 32'(e_rec[l]));
  endtask

  task automatic clear_model();
    e_valid = 1'b0; e_inv = 1'b0; e_ftz = 1'b0;
    e_rm = '0; e_mask = '0; e_tag = '0;
    for (int l = 0; l < L; l++) e_rec[l] = '0;
  endtask

  localparam logic [31:0] ONE = 32'h3F800000;

  initial begin
    rst_n = 1'b0;
    bus.in_valid_i = 1'b0; bus.a_i = '0; bus.b_i = '0; bus.rm_i = '0; bus.ftz_i = 1'b0;
    bus.lane_mask_i = '0; bus.tag_i = '0; bus.out_ready_i = 1'b1; bus.flag_clr_i = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst/valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst/ready", 32'(bus.in_ready_o), 32'd1);
    chk("rst/flags", 32'({bus.flag_inv_o, bus.flag_ftz_o}), 32'd0);
    chk("rst/lane0", 32'(obs_rec(0)), 32'd0);
    rst_n = 1'b1;

    drive({96'h0, ONE}, {96'h0, ONE}, 1'b0, 4'b0001, 8'h01, 1'b0);
    cycle("one");
    chk("one/shift", 32'(bus.out_shift_amt_o[8:0]), 32'd26);
    chk("one/exp", 32'(bus.out_exp_shifted_o[8:0]), 32'd128);
    chk("one/bits", 32'({bus.out_may_be_sub_o[0], bus.out_special_valid_o[0], bus.out_prod_sign_o[0]}), 32'd0);

    drive({96'h0, 32'h00000001}, {96'h0, ONE}, 1'b0, 4'b0001, 8'h02, 1'b0);
    cycle("sub");
    chk("sub/shift", 32'(bus.out_shift_amt_o[8:0]), 32'd27);
    chk("sub/exp", 32'(bus.out_exp_shifted_o[8:0]), 32'd1);
    chk("sub/mbs", 32'(bus.out_may_be_sub_o[0]), 32'd1);

    drive({96'h0, 32'h00000001}, {96'h0, ONE}, 1'b1, 4'b0001, 8'h03, 1'b0);
    cycle("ftz");
    chk("ftz/bits", 32'({bus.out_haszero_o[0], bus.out_special_valid_o[0], bus.flag_ftz_o}), 32'h7);

    drive({96'h0, 32'h00000000}, {96'h0, 32'hFF800000}, 1'b0, 4'b0001, 8'h04, 1'b0);
    cycle("zinf");
    chk("zinf/bits", 32'({bus.out_nan_o[0], bus.out_inf_o[0], bus.out_inv_o[0],
                         bus.out_haszero_o[0], bus.out_prod_sign_o[0]}), 32'h1F);
    chk("zinf/flag_inv", 32'(bus.flag_inv_o), 32'd1);

    bus.in_valid_i = 1'b0;
    bus.flag_clr_i = 1'b1;
    cycle("clr");
    chk("clr/flag_inv", 32'(bus.flag_inv_o), 32'd0);

    drive({96'h0, 32'h7F000000}, {96'h0, 32'h7F000000}, 1'b0, 4'b0001, 8'h05, 1'b0);
    cycle("ov");
    chk("ov/early_ov", 32'(bus.out_early_ov_o[0]), 32'd1);

    drive({64'h0, 32'h7F800001, ONE}, {64'h0, ONE, ONE}, 1'b0, 4'b0001, 8'h06, 1'b0);
    cycle("masked");
    chk("masked/lane1", 32'(obs_rec(1)), 32'd0);
    chk("masked/flag_inv", 32'(bus.flag_inv_o), 32'd0);

    drive({96'h0, 32'h7F800001}, {96'h0, ONE}, 1'b0, 4'b0001, 8'h07, 1'b0);
    cycle("snan");
    chk("snan/bits", 32'({bus.out_nan_o[0], bus.out_inv_o[0], bus.flag_inv_o}), 32'h7);

    drive(rnd_vec(), rnd_vec(), 1'b0, 4'b1111, 8'h10, 1'b0);
    cycle("bp_load");
    bus.out_ready_i = 1'b0;
    drive(rnd_vec(), rnd_vec(), 1'b0, 4'($urandom), 8'h01, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle($sformatf("stall%0d", k));
      chk("stall/ready", 32'(bus.in_ready_o), 32'd0);
      chk("stall/tag", 32'(bus.out_tag_o), 32'h10);
    end
    bus.out_ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) drive(rnd_vec(), rnd_vec(), 1'($urandom), 4'($urandom), 8'(k), 1'b0);
      cycle($sformatf("drain%0d", k));
      chk("drain/tag", 32'(bus.out_tag_o), 32'(k));
    end

    drive({96'h0, 32'h7F800001}, {96'h0, ONE}, 1'b1, 4'b0001, 8'h55, 1'b0);
    cycle("pre_rst");
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst/valid", 32'(bus.out_valid_o), 32'd0);
    chk("midrst/ready", 32'(bus.in_ready_o), 32'd1);
    chk("midrst/flags", 32'({bus.flag_inv_o, bus.flag_ftz_o}), 32'd0);
    chk("midrst/tag", 32'(bus.out_tag_o), 32'd0);
    chk("midrst/lane0", 32'(obs_rec(0)), 32'd0);
    rst_n = 1'b1;
    clear_model();

    for (int i = 0; i < 80; i++) begin
      drive(rnd_vec(), rnd_vec(), 1'($urandom), 4'($urandom), 8'($urandom),
            ($urandom_range(0, 5) == 0));
      bus.in_valid_i  = ($urandom_range(0, 3) != 0);
      bus.out_ready_i = ($urandom_range(0, 3) != 0);
      cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
